// File: rtl/switch_led_pkg.sv
// Shared types and helpers for the switch debounce / LED toggle controller.
// The FSM state encoding, the 25 MHz debounce default and round-robin index stepping.
package switch_led_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  // 10 ms of stable input at 25 MHz
  localparam int DEBOUNCE_LIMIT_25MHZ = 250000;

  function automatic int rr_next(input int idx, input int num);
    if (idx + 1 >= num) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/switch_led_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i,
// wrapping modulo NUM_SW, as a one-hot vector plus its binary index.
module rr_arbiter #(
  parameter int NUM_SW = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_SW-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_SW-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  function automatic int wrap_idx(input int v);
    if (v >= NUM_SW) begin
      return v - NUM_SW;
    end
    return v;
  endfunction

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int off = 0; off < NUM_SW; off++) begin
      k = wrap_idx(int'(ptr_i) + off);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/switch_led_ctrl.sv
// Debounce-and-toggle controller sharing one debounce timer across NUM_SW switches.
// Define TOGGLE_ON_PRESS_EN to toggle LEDs on press commits instead of release commits.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_25MHZ
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_LED,
  output logic [NUM_SW-1:0] o_Toggle,
  output logic              o_Busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
  localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_COUNT = COUNT;

`ifdef TOGGLE_ON_PRESS_EN
  localparam logic TOGGLE_LEVEL = 1'b1;
`else
  localparam logic TOGGLE_LEVEL = 1'b0;
`endif

  logic [NUM_SW-1:0] sync1_q, w_Sync;
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [NUM_SW-1:0] led_q, led_d;
  logic [NUM_SW-1:0] tog_q, tog_d;
  logic [NUM_SW-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:0]        state_q, state_d;
  logic              busy_q, busy_d;

  logic [NUM_SW-1:0] pend;
  logic [NUM_SW-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [IDX_W-1:0]  ptr_after;

  assign pend      = w_Sync ^ stable_q;
  assign ptr_after = IDX_W'(rr_next(int'(gidx_q), NUM_SW));

  rr_arbiter #(
    .NUM_SW (NUM_SW),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i  (pend),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    stable_d = stable_q;
    led_d    = led_q;
    tog_d    = '0;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          gidx_d  = arb_idx;
          gnt_d   = arb_gnt;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        // Granted input fell back to its debounced level: give up the timer
        if (w_Sync[gidx_q] == stable_q[gidx_q]) begin
          ptr_d   = ptr_after;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = (stable_q & ~gnt_q) | (w_Sync & gnt_q);
          ptr_d    = ptr_after;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
          if (w_Sync[gidx_q] == TOGGLE_LEVEL) begin
            led_d = led_q ^ gnt_q;
            tog_d = gnt_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q  <= '0;
      w_Sync   <= '0;
      stable_q <= '0;
      led_q    <= '0;
      tog_q    <= '0;
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
    end else begin
      sync1_q  <= i_Switch;
      w_Sync   <= sync1_q;
      stable_q <= stable_d;
      led_q    <= led_d;
      tog_q    <= tog_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      busy_q   <= busy_d;
    end
  end

  assign o_LED    = led_q;
  assign o_Toggle = tog_q;
  assign o_Busy   = busy_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Scoreboard bench for switch_led_ctrl (NUM_SW=4, DEBOUNCE_LIMIT=8); expected toggle
// events are queued by the stimulus and matched by a monitor whenever o_Toggle fires.
module tb_switch_led_ctrl;

`ifdef TOGGLE_ON_PRESS_EN
  localparam bit PRESS_TOGGLES = 1'b1;
`else
  localparam bit PRESS_TOGGLES = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b1111;
  logic [3:0] led;
  logic [3:0] tog;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         at;
    logic [3:0] tmask;
    logic [3:0] led;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  switch_led_ctrl #(
    .NUM_SW         (4),
    .DEBOUNCE_LIMIT (8)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .o_LED    (led),
    .o_Toggle (tog),
    .o_Busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expected LED toggle for a commit; only the commit direction that toggles is queued
  task automatic commit_evt(input bit is_press, input int at, input logic [3:0] tmask,
                            input logic [3:0] led_after);
    if (is_press == PRESS_TOGGLES) exp_q.push_back('{at, tmask, led_after});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw  = 4'b0000;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (cyc > 5000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 5000", cyc);
      $fatal(1);
    end
    if (tog !== 4'b0000) begin
      check("toggle_onehot", $countones(tog), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_toggle", {28'd0, tog}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("toggle_cycle", cyc, mon_e.at);
        check("toggle_mask", {28'd0, tog}, {28'd0, mon_e.tmask});
        check("toggle_led", {28'd0, led}, {28'd0, mon_e.led});
      end
    end
  end

  initial begin
    int c;

    // Reset with all switches pressed
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_led", {28'd0, led}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_toggle", {28'd0, tog}, 32'd0);
    end
    sw = 4'b0000;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Clean press/release on switch 0, twice
    c = cyc;
    sw[0] = 1'b1;
    commit_evt(1'b1, c + 11, 4'b0001, 4'b0001);
    tick(20);
    sw[0] = 1'b0;
    commit_evt(1'b0, c + 31, 4'b0001, 4'b0001);
    tick(5);
    check("t2_busy_counting", {31'd0, busy}, 32'd1);
    tick(15);
    check("t2_busy_idle", {31'd0, busy}, 32'd0);
    check("t2_led_on", {28'd0, led}, 32'h1);
    sw[0] = 1'b1;
    commit_evt(1'b1, c + 51, 4'b0001, 4'b0000);
    tick(20);
    sw[0] = 1'b0;
    commit_evt(1'b0, c + 71, 4'b0001, 4'b0000);
    tick(20);
    check("t2_led_off", {28'd0, led}, 32'h0);

    // Bounce on switch 1 after a committed press
    do_reset();
    c = cyc;
    sw[1] = 1'b1;
    commit_evt(1'b1, c + 11, 4'b0010, 4'b0010);
    tick(20);
    for (int seg = 0; seg < 10; seg++) begin
      sw[1] = (seg % 2 == 1);
      tick(3);
    end
    check("t3_abort_idle", {31'd0, busy}, 32'd0);
    sw[1] = 1'b0;
    commit_evt(1'b0, c + 61, 4'b0010, 4'b0010);
    tick(20);
    check("t3_led", {28'd0, led}, 32'h2);

    // Simultaneous press then release of all four switches
    do_reset();
    c = cyc;
    sw = 4'b1111;
    commit_evt(1'b1, c + 11, 4'b0001, 4'b0001);
    commit_evt(1'b1, c + 20, 4'b0010, 4'b0011);
    commit_evt(1'b1, c + 29, 4'b0100, 4'b0111);
    commit_evt(1'b1, c + 38, 4'b1000, 4'b1111);
    tick(50);
    sw = 4'b0000;
    commit_evt(1'b0, c + 61, 4'b0001, 4'b0001);
    commit_evt(1'b0, c + 70, 4'b0010, 4'b0011);
    commit_evt(1'b0, c + 79, 4'b0100, 4'b0111);
    commit_evt(1'b0, c + 88, 4'b1000, 4'b1111);
    tick(50);
    check("t4_led_all", {28'd0, led}, 32'hF);

    // Reset in the middle of a release count on switch 2
    do_reset();
    c = cyc;
    sw[2] = 1'b1;
    commit_evt(1'b1, c + 11, 4'b0100, 4'b0100);
    tick(20);
    sw[2] = 1'b0;
    tick(7);
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("t5_led_after_rst", {28'd0, led}, 32'h0);
    check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    tick(20);
    check("t5_led_later", {28'd0, led}, 32'h0);

    // Press then release on switch 3
    do_reset();
    c = cyc;
    sw[3] = 1'b1;
    commit_evt(1'b1, c + 11, 4'b1000, 4'b1000);
    tick(15);
    check("t6_led_after_press", {28'd0, led}, PRESS_TOGGLES ? 32'h8 : 32'h0);
    tick(5);
    sw[3] = 1'b0;
    commit_evt(1'b0, c + 31, 4'b1000, 4'b1000);
    tick(20);
    check("t6_led_final", {28'd0, led}, 32'h8);

    tick(5);
    check("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
